console_buffer_ctrl: RTL and testbench

//  Arbitrates one single-port character/attribute RAM between the pixel-rate console fetch and a host command port.

---
 rtl/console_pkg.sv | 29 ++
 rtl/console_fetch_timer.sv | 41 ++++
 rtl/console_buffer_ctrl.sv | 179 +++++++++++++++++
 tb/tb_console_buffer_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Shared types and defaults for the text console buffer controller.
package console_pkg;

    localparam int COLS_DEF   = 80;
    localparam int ROWS_DEF   = 30;
    localparam int CELL_COUNT = COLS_DEF * ROWS_DEF;

    typedef enum logic [1:0] {
        CMD_WRITE      = 2'd0,
        CMD_SET_CURSOR = 2'd1,
        CMD_CLEAR      = 2'd2,
        CMD_SET_SCROLL = 2'd3
    } cmd_e;

    typedef struct packed {
        logic [7:0] attr;
        logic [7:0] chr;
    } cell_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    function automatic logic [11:0] cell_inc(input logic [11:0] idx, input logic [11:0] last);
        return (idx == last) ? 12'd0 : idx + 12'd1;
    endfunction

endpackage

// File: rtl/console_fetch_timer.sv
// Derives the display fetch slot and target text cell from the HDMI pixel counters.
module console_fetch_timer #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int FRAME_WIDTH  = 800,
    parameter int FRAME_HEIGHT = 525
) (
    input  logic [9:0] cx,
    input  logic [9:0] cy,
    output logic       fetch_slot,
    output logic       fetch_valid,
    output logic [6:0] fetch_col,
    output logic [5:0] fetch_row
);

    logic [10:0] nx_s;
    logic [10:0] ny_s;

    // The fetch issued at cx[2:0]==6 targets the cell starting two pixels later.
    always_comb begin
        nx_s = {1'b0, cx} + 11'd2;
        ny_s = {1'b0, cy};
        if (nx_s >= 11'(FRAME_WIDTH)) begin
            nx_s = nx_s - 11'(FRAME_WIDTH);
            ny_s = ny_s + 11'd1;
            if (ny_s == 11'(FRAME_HEIGHT)) begin
                ny_s = 11'd0;
            end else begin
                ny_s = ny_s;
            end
        end else begin
            nx_s = nx_s;
        end
    end

    assign fetch_slot  = (cx[2:0] == 3'd6);
    assign fetch_col   = 7'(nx_s >> 3);
    assign fetch_row   = 6'(ny_s >> 4);
    assign fetch_valid = fetch_slot && (int'(fetch_col) < COLS) && (int'(fetch_row) < ROWS);

endmodule

// File: rtl/console_buffer_ctrl.sv
// Shares one char/attr RAM between console display fetch and host commands.
// Optional hardware scroll is built when CONSOLE_SCROLL_EN is defined.
module console_buffer_ctrl
    import console_pkg::*;
#(
    parameter int COLS         = COLS_DEF,
    parameter int ROWS         = ROWS_DEF,
    parameter int FRAME_WIDTH  = 800,
    parameter int FRAME_HEIGHT = 525
) (
    input  logic        clk_pixel,
    input  logic        resetn,
    input  logic [9:0]  cx,
    input  logic [9:0]  cy,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [1:0]  host_cmd,
    input  logic [15:0] host_data,
    output logic [11:0] ram_addr,
    output logic        ram_we,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic [7:0]  character,
    output logic [7:0]  attribute,
    output logic        busy
);

    localparam int          CELLS     = COLS * ROWS;
    localparam logic [11:0] LAST_CELL = 12'(CELLS - 1);

    logic        fetch_slot_s;
    logic        fetch_valid_s;
    logic [6:0]  fetch_col_s;
    logic [5:0]  fetch_row_s;
    logic [5:0]  row_phys_s;
    logic [11:0] fetch_addr_s;
    cell_t       rd_cell_s;

    state_e      state_r, state_nx_s;
    logic [11:0] cursor_r, cursor_nx_s;
    logic [11:0] ptr_r, ptr_nx_s;
    logic [15:0] fill_r, fill_nx_s;
    logic        run_r;
    logic        pending_r;

    console_fetch_timer #(
        .COLS         (COLS),
        .ROWS         (ROWS),
        .FRAME_WIDTH  (FRAME_WIDTH),
        .FRAME_HEIGHT (FRAME_HEIGHT)
    ) u_timer (
        .cx          (cx),
        .cy          (cy),
        .fetch_slot  (fetch_slot_s),
        .fetch_valid (fetch_valid_s),
        .fetch_col   (fetch_col_s),
        .fetch_row   (fetch_row_s)
    );

`ifdef CONSOLE_SCROLL_EN
    logic [5:0] scroll_r, scroll_nx_s;
    logic [6:0] row_sum_s;

    // Display row offset by the scroll register, wrapping within the text area.
    always_comb begin
        row_sum_s = {1'b0, fetch_row_s} + {1'b0, scroll_r};
        if (row_sum_s >= 7'(ROWS)) begin
            row_phys_s = 6'(row_sum_s - 7'(ROWS));
        end else begin
            row_phys_s = 6'(row_sum_s);
        end
    end
`else
    assign row_phys_s = fetch_row_s;
`endif

    assign fetch_addr_s = 12'(int'(row_phys_s) * COLS + int'(fetch_col_s));
    assign rd_cell_s    = cell_t'(ram_rdata);
    assign host_ready   = run_r && (state_r == ST_IDLE) && !fetch_slot_s;
    assign busy         = (state_r == ST_CLEAR);

    // Arbitration: fetch slot first, then clear sweep, then host command.
    always_comb begin
        state_nx_s  = state_r;
        cursor_nx_s = cursor_r;
        ptr_nx_s    = ptr_r;
        fill_nx_s   = fill_r;
`ifdef CONSOLE_SCROLL_EN
        scroll_nx_s = scroll_r;
`endif
        ram_addr    = 12'd0;
        ram_we      = 1'b0;
        ram_wdata   = 16'd0;
        if (!run_r) begin
            ram_addr = 12'd0;
        end else if (fetch_slot_s) begin
            ram_addr = fetch_valid_s ? fetch_addr_s : 12'd0;
        end else if (state_r == ST_CLEAR) begin
            ram_addr  = ptr_r;
            ram_we    = 1'b1;
            ram_wdata = fill_r;
            if (ptr_r == LAST_CELL) begin
                state_nx_s  = ST_IDLE;
                cursor_nx_s = 12'd0;
                ptr_nx_s    = 12'd0;
            end else begin
                ptr_nx_s = ptr_r + 12'd1;
            end
        end else if (host_valid) begin
            case (cmd_e'(host_cmd))
                CMD_WRITE: begin
                    ram_addr    = cursor_r;
                    ram_we      = 1'b1;
                    ram_wdata   = host_data;
                    cursor_nx_s = cell_inc(cursor_r, LAST_CELL);
                end
                CMD_SET_CURSOR: begin
                    cursor_nx_s = (host_data < 16'(CELLS)) ? 12'(host_data) : 12'd0;
                end
                CMD_CLEAR: begin
                    fill_nx_s  = host_data;
                    ptr_nx_s   = 12'd0;
                    state_nx_s = ST_CLEAR;
                end
                CMD_SET_SCROLL: begin
`ifdef CONSOLE_SCROLL_EN
                    scroll_nx_s = (host_data < 16'(ROWS)) ? 6'(host_data) : 6'd0;
`else
                    state_nx_s = state_r;
`endif
                end
                default: begin
                    state_nx_s = state_r;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Control state: FSM, cursor, sweep pointer, fill value and optional scroll.
    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            state_r  <= ST_IDLE;
            cursor_r <= 12'd0;
            ptr_r    <= 12'd0;
            fill_r   <= 16'd0;
            run_r    <= 1'b0;
`ifdef CONSOLE_SCROLL_EN
            scroll_r <= 6'd0;
`endif
        end else begin
            state_r  <= state_nx_s;
            cursor_r <= cursor_nx_s;
            ptr_r    <= ptr_nx_s;
            fill_r   <= fill_nx_s;
            run_r    <= 1'b1;
`ifdef CONSOLE_SCROLL_EN
            scroll_r <= scroll_nx_s;
`endif
        end
    end

    // Display outputs update on the edge closing the cx[2:0]==7 cycle; blank cells read as zero.
    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            pending_r <= 1'b0;
            character <= 8'd0;
            attribute <= 8'd0;
        end else begin
            pending_r <= run_r && fetch_valid_s;
            if (cx[2:0] == 3'd7) begin
                character <= pending_r ? rd_cell_s.chr  : 8'd0;
                attribute <= pending_r ? rd_cell_s.attr : 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_console_buffer_ctrl.sv
// Directed self-checking bench for console_buffer_ctrl with a behavioural 1-cycle RAM.
module tb_console_buffer_ctrl;

    logic        clk_pixel = 1'b0;
    logic        resetn;
    logic [9:0]  cx, cy;
    logic        host_valid;
    logic        host_ready;
    logic [1:0]  host_cmd;
    logic [15:0] host_data;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [7:0]  character, attribute;
    logic        busy;

    logic [15:0] mem [0:4095];
    logic        load_en;
    int          checks = 0;
    int          errors = 0;

    always #5 clk_pixel = ~clk_pixel;

    console_buffer_ctrl dut (
        .clk_pixel  (clk_pixel),
        .resetn     (resetn),
        .cx         (cx),
        .cy         (cy),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_cmd   (host_cmd),
        .host_data  (host_data),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .character  (character),
        .attribute  (attribute),
        .busy       (busy)
    );

    // Single-port RAM with registered read; preload writes cell k = k.
    always @(posedge clk_pixel) begin
        if (load_en) begin
            for (int k = 0; k < 4096; k++) mem[k] <= (k < 2400) ? 16'(k) : 16'd0;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic send(input logic [1:0] cmd, input logic [15:0] data, input string tag);
        host_valid = 1'b1;
        host_cmd   = cmd;
        host_data  = data;
        #1;
        check_eq(tag, 32'(host_ready), 32'd1);
        tick();
        host_valid = 1'b0;
    endtask

    task automatic write_chk(input logic [15:0] data, input logic [11:0] exp_addr, input string tag);
        host_valid = 1'b1;
        host_cmd   = 2'd0;
        host_data  = data;
        #1;
        check_eq({tag, "_we"}, 32'(ram_we), 32'd1);
        check_eq({tag, "_addr"}, 32'(ram_addr), 32'(exp_addr));
        check_eq({tag, "_wdata"}, 32'(ram_wdata), 32'(data));
        tick();
        host_valid = 1'b0;
    endtask

    initial begin
        int writes, viol, badw, rdy_busy, done, bad_cells, x;
        resetn = 1'b0; load_en = 1'b1;
        cx = 10'd0; cy = 10'd0;
        host_valid = 1'b0; host_cmd = 2'd0; host_data = 16'd0;
        #2;
        check_eq("rst_ready", 32'(host_ready), 32'd0);
        check_eq("rst_we", 32'(ram_we), 32'd0);
        check_eq("rst_addr", 32'(ram_addr), 32'd0);
        check_eq("rst_char", 32'(character), 32'd0);
        check_eq("rst_attr", 32'(attribute), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        tick();
        load_en = 1'b0;
        tick();
        resetn = 1'b1;
        tick();

        // Line sweep at cy=0 over preloaded RAM
        for (int i = 0; i < 800; i++) begin
            cx = 10'(i);
            #1;
            if (i == 8)   check_eq("sweep_char_col1", 32'(character), 32'd1);
            if (i == 8)   check_eq("sweep_attr_col1", 32'(attribute), 32'd0);
            if (i == 16)  check_eq("sweep_char_col2", 32'(character), 32'd2);
            if (i == 632) check_eq("sweep_char_col79", 32'(character), 32'd79);
            if (i == 640) check_eq("sweep_char_blank", 32'(character), 32'd0);
            tick();
        end

        // Host writes and cursor wrap
        cx = 10'd0; cy = 10'd0;
        send(2'd1, 16'd79, "setcur79_ready");
        write_chk(16'h4741, 12'd79, "wr79");
        check_eq("mem79", 32'(mem[79]), 32'h4741);
        write_chk(16'h1111, 12'd80, "wr80");
        send(2'd1, 16'd2399, "setcur2399_ready");
        write_chk(16'h2222, 12'd2399, "wr2399");
        write_chk(16'h3333, 12'd0, "wr_wrap0");
        send(2'd1, 16'd2400, "setcur_oob_ready");
        write_chk(16'h4444, 12'd0, "wr_oob0");

        // Fetch slot blocks host; accepted next cycle
        send(2'd1, 16'd500, "setcur500_ready");
        cx = 10'd6;
        host_valid = 1'b1; host_cmd = 2'd0; host_data = 16'h5555;
        #1;
        check_eq("slot_ready", 32'(host_ready), 32'd0);
        check_eq("slot_we", 32'(ram_we), 32'd0);
        check_eq("slot_addr", 32'(ram_addr), 32'd1);
        tick();
        cx = 10'd7;
        #1;
        check_eq("after_slot_ready", 32'(host_ready), 32'd1);
        check_eq("after_slot_we", 32'(ram_we), 32'd1);
        check_eq("after_slot_addr", 32'(ram_addr), 32'd500);
        tick();
        host_valid = 1'b0;
        check_eq("mem500", 32'(mem[500]), 32'h5555);
        check_eq("slot_char", 32'(character), 32'd1);

        // CLEAR sweep
        cx = 10'd0;
        send(2'd2, 16'h0720, "clear_ready");
        writes = 0; viol = 0; badw = 0; rdy_busy = 0; done = 0; x = 1;
        check_eq("clear_busy", 32'(busy), 32'd1);
        for (int n = 0; n < 5000; n++) begin
            cx = 10'(x);
            #1;
            if (!busy) begin
                done = 1;
                break;
            end
            if (host_ready) rdy_busy++;
            if (ram_we) begin
                writes++;
                if (ram_wdata != 16'h0720) badw++;
                if (cx[2:0] == 3'd6) viol++;
            end
            tick();
            x = (x == 799) ? 0 : x + 1;
        end
        check_eq("clear_done", 32'(done), 32'd1);
        check_eq("clear_writes", 32'(writes), 32'd2400);
        check_eq("clear_slot_writes", 32'(viol), 32'd0);
        check_eq("clear_bad_data", 32'(badw), 32'd0);
        check_eq("clear_ready_busy", 32'(rdy_busy), 32'd0);
        bad_cells = 0;
        for (int k = 0; k < 2400; k++) if (mem[k] != 16'h0720) bad_cells++;
        check_eq("clear_cells", 32'(bad_cells), 32'd0);
        cx = 10'd0;
        write_chk(16'h1E41, 12'd0, "wr_after_clear");

        // Line wrap, frame wrap and vertical blanking fetches
        cx = 10'd798; cy = 10'd15;
        #1;
        check_eq("wrap_row1_addr", 32'(ram_addr), 32'd80);
        check_eq("wrap_row1_we", 32'(ram_we), 32'd0);
        cx = 10'd14; cy = 10'd20;
        #1;
        check_eq("row1_col2_addr", 32'(ram_addr), 32'd82);
        cx = 10'd798; cy = 10'd524;
        #1;
        check_eq("frame_wrap_addr", 32'(ram_addr), 32'd0);
        tick();
        cx = 10'd799;
        tick();
        cx = 10'd0;
        #1;
        check_eq("frame_wrap_char", 32'(character), 32'h41);
        check_eq("frame_wrap_attr", 32'(attribute), 32'h1E);
        cx = 10'd798; cy = 10'd480;
        #1;
        check_eq("vblank_addr", 32'(ram_addr), 32'd0);
        tick();
        cx = 10'd799;
        tick();
        cx = 10'd0;
        #1;
        check_eq("vblank_char", 32'(character), 32'd0);
        check_eq("vblank_attr", 32'(attribute), 32'd0);

        // Scroll
        cy = 10'd0;
        send(2'd3, 16'd29, "scroll_ready");
        cx = 10'd798; cy = 10'd16;
        #1;
`ifdef CONSOLE_SCROLL_EN
        check_eq("scroll29_addr", 32'(ram_addr), 32'd0);
        cx = 10'd0; cy = 10'd0;
        send(2'd3, 16'd40, "scroll_oob_ready");
        cx = 10'd798; cy = 10'd16;
        #1;
        check_eq("scroll_oob_addr", 32'(ram_addr), 32'd80);
`else
        check_eq("noscroll_addr", 32'(ram_addr), 32'd80);
`endif

        // Reset in the middle of a CLEAR
        cx = 10'd0; cy = 10'd0;
        send(2'd2, 16'h0000, "clear2_ready");
        for (int i = 1; i < 4; i++) begin
            cx = 10'(i);
            tick();
        end
        check_eq("clear2_busy", 32'(busy), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_we", 32'(ram_we), 32'd0);
        check_eq("midrst_ready", 32'(host_ready), 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        tick();
        check_eq("postrst_busy", 32'(busy), 32'd0);
        check_eq("postrst_ready", 32'(host_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
